// File: rtl/tetris_board_writer.sv
// Board writer for the 10x20 playfield: commits locked boards, blinks full rows and collapses them.
// Row blinking is built only when TETRIS_LINE_FLASH_EN is defined; otherwise full rows collapse at once.
module tetris_board_writer #(
    parameter int FLASH_FRAMES = 30,
    parameter int BLINK_PERIOD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         lock_valid,
    output logic         lock_ready,
    input  logic [199:0] lock_board,
    output logic [199:0] objectMatrix,
    output logic [199:0] flash,
    output logic         busy,
    output logic         lines_valid,
    output logic [4:0]   lines_cleared,
    output logic [15:0]  total_lines
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
`ifdef TETRIS_LINE_FLASH_EN
        FLASH    = 3'd2,
`endif
        COLLAPSE = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t        state_r;
    logic [199:0]  board_r;
    logic [19:0]   full_mask_r;
    logic [4:0]    cnt_r;
    logic [4:0]    cursor_r;
    logic          lines_valid_r;
    logic [4:0]    lines_cleared_r;
    logic [15:0]   total_lines_r;
    logic [19:0]   scan_mask_s;
    logic [4:0]    scan_cnt_s;

    function automatic logic [19:0] row_full(input logic [199:0] b);
        logic [19:0] m;
        for (int r = 0; r < 20; r++) m[r] = &b[r*10 +: 10];
        return m;
    endfunction

    function automatic logic [4:0] popcount20(input logic [19:0] m);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 20; i++) n = n + {4'd0, m[i]};
        return n;
    endfunction

    // Rows 0..cur-1 fall one row; row 0 empties; rows below cur are untouched.
    function automatic logic [199:0] drop_rows(input logic [199:0] b, input logic [4:0] cur);
        logic [199:0] o;
        o = b;
        for (int r = 1; r < 20; r++) begin
            if (5'(r) <= cur) o[r*10 +: 10] = b[(r-1)*10 +: 10];
            else              o[r*10 +: 10] = b[r*10 +: 10];
        end
        o[9:0] = 10'd0;
        return o;
    endfunction

    function automatic logic [19:0] drop_mask(input logic [19:0] m, input logic [4:0] cur);
        logic [19:0] o;
        o = m;
        for (int r = 1; r < 20; r++) begin
            if (5'(r) <= cur) o[r] = m[r-1];
            else              o[r] = m[r];
        end
        o[0] = 1'b0;
        return o;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] t, input logic [4:0] c);
        logic [16:0] s;
        s = {1'b0, t} + {12'd0, c};
        if (s[16]) return 16'hFFFF;
        else       return s[15:0];
    endfunction

`ifdef TETRIS_LINE_FLASH_EN
    localparam int FC_W = $clog2(FLASH_FRAMES + 1);

    logic [FC_W-1:0] frame_cnt_r;
    logic [199:0]    flash_r;

    function automatic logic [199:0] expand_rows(input logic [19:0] m);
        logic [199:0] o;
        for (int r = 0; r < 20; r++) o[r*10 +: 10] = {10{m[r]}};
        return o;
    endfunction

    function automatic logic blink_on(input int unsigned n);
        return ((n / BLINK_PERIOD) % 32'd2) == 32'd0;
    endfunction

    assign flash = flash_r;
`else
    logic unused_s;
    assign unused_s = frame_tick ^ (32'(FLASH_FRAMES) != 32'd0) ^ (32'(BLINK_PERIOD) != 32'd0);
    assign flash    = {200{1'b0}};
`endif

    assign scan_mask_s   = row_full(board_r);
    assign scan_cnt_s    = popcount20(scan_mask_s);
    assign objectMatrix  = board_r;
    assign lock_ready    = (state_r == IDLE) & ~rst;
    assign busy          = (state_r != IDLE);
    assign lines_valid   = lines_valid_r;
    assign lines_cleared = lines_cleared_r;
    assign total_lines   = total_lines_r;

    // Control FSM: capture, scan, optional blink, collapse and line accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            board_r         <= {200{1'b0}};
            full_mask_r     <= 20'd0;
            cnt_r           <= 5'd0;
            cursor_r        <= 5'd0;
            lines_valid_r   <= 1'b0;
            lines_cleared_r <= 5'd0;
            total_lines_r   <= 16'd0;
`ifdef TETRIS_LINE_FLASH_EN
            frame_cnt_r     <= '0;
            flash_r         <= {200{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (lock_valid) begin
                        board_r <= lock_board;
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    full_mask_r <= scan_mask_s;
                    cnt_r       <= scan_cnt_s;
                    cursor_r    <= 5'd19;
`ifdef TETRIS_LINE_FLASH_EN
                    frame_cnt_r <= '0;
`endif
                    if (scan_cnt_s == 5'd0) begin
                        state_r         <= DONE;
                        lines_valid_r   <= 1'b1;
                        lines_cleared_r <= 5'd0;
                    end else begin
`ifdef TETRIS_LINE_FLASH_EN
                        state_r <= FLASH;
                        flash_r <= expand_rows(scan_mask_s);
`else
                        state_r <= COLLAPSE;
`endif
                    end
                end
`ifdef TETRIS_LINE_FLASH_EN
                FLASH: begin
                    if (frame_tick) begin
                        if (frame_cnt_r == FC_W'(FLASH_FRAMES - 1)) begin
                            state_r <= COLLAPSE;
                            flash_r <= {200{1'b0}};
                        end else begin
                            frame_cnt_r <= frame_cnt_r + FC_W'(32'd1);
                            flash_r     <= blink_on(32'(frame_cnt_r) + 32'd1) ?
                                           expand_rows(full_mask_r) : {200{1'b0}};
                        end
                    end
                end
`endif
                // Cursor holds on a full row so the row that just fell into it is re-examined.
                COLLAPSE: begin
                    if (full_mask_r == 20'd0) begin
                        state_r         <= DONE;
                        lines_valid_r   <= 1'b1;
                        lines_cleared_r <= cnt_r;
                        total_lines_r   <= sat_add(total_lines_r, cnt_r);
                    end else if (full_mask_r[cursor_r]) begin
                        board_r     <= drop_rows(board_r, cursor_r);
                        full_mask_r <= drop_mask(full_mask_r, cursor_r);
                    end else begin
                        cursor_r <= cursor_r - 5'd1;
                    end
                end
                DONE: begin
                    lines_valid_r <= 1'b0;
                    state_r       <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_board_writer.sv
// Directed bench for tetris_board_writer with a gravity-model scoreboard checked on lines_valid.
module tb_tetris_board_writer;
    logic         clk = 1'b0;
    logic         rst, frame_tick, lock_valid;
    logic [199:0] lock_board;
    logic         lock_ready, busy, lines_valid;
    logic [199:0] objectMatrix, flash;
    logic [4:0]   lines_cleared;
    logic [15:0]  total_lines;

    int checks = 0;
    int failures = 0;
    int lv_pulses = 0;
    logic [15:0] model_total;

    typedef struct {
        logic [199:0] board;
        logic [4:0]   cleared;
        logic [15:0]  total;
    } exp_t;
    exp_t sb_q[$];

    always #20 clk = ~clk;

    tetris_board_writer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .lock_valid    (lock_valid),
        .lock_ready    (lock_ready),
        .lock_board    (lock_board),
        .objectMatrix  (objectMatrix),
        .flash         (flash),
        .busy          (busy),
        .lines_valid   (lines_valid),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: keep non-full rows in order, packed against the bottom.
    function automatic logic [199:0] gravity(input logic [199:0] b, output int n);
        logic [199:0] o;
        int dst;
        o = '0;
        dst = 19;
        n = 0;
        for (int r = 19; r >= 0; r--) begin
            if (&b[r*10 +: 10]) n++;
            else begin
                o[dst*10 +: 10] = b[r*10 +: 10];
                dst--;
            end
        end
        return o;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (lines_valid === 1'b1) begin
            lv_pulses++;
            checks++;
            assert (sb_q.size() > 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=lines_valid_pulse expected=none");
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_board", objectMatrix, e.board);
                check("sb_cleared", lines_cleared, e.cleared);
                check("sb_total", total_lines, e.total);
                check("sb_flash_off", flash, '0);
            end
        end
    end

    task automatic run_event(input string tag, input logic [199:0] b, input bit inject,
                             input int budget, output int lat);
        int n;
        exp_t e;
        e.board = gravity(b, n);
        if (int'(model_total) + n > 65535) model_total = 16'hFFFF;
        else model_total = model_total + 16'(n);
        e.cleared = 5'(n);
        e.total = model_total;
        check({tag, "_ready"}, lock_ready, 1'b1);
        lock_board = b;
        lock_valid = 1'b1;
        sb_q.push_back(e);
        step();
        lock_valid = 1'b0;
        check({tag, "_captured"}, objectMatrix, b);
        check({tag, "_busy"}, busy, 1'b1);
        lat = 0;
        while (lines_valid !== 1'b1 && lat < budget) begin
`ifdef TETRIS_LINE_FLASH_EN
            frame_tick = lat[0];
`else
            frame_tick = 1'($urandom);
`endif
            if (inject && lat == 1) begin
                lock_valid = 1'b1;
                lock_board = {200{1'b1}};
            end
            step();
            lat++;
            if (inject && lat == 2) begin
                check({tag, "_ignore_ready"}, lock_ready, 1'b0);
`ifdef TETRIS_LINE_FLASH_EN
                check({tag, "_ignore_board"}, objectMatrix, b);
`endif
            end
            if (inject && lat == 3) lock_valid = 1'b0;
        end
        frame_tick = 1'b0;
        lock_valid = 1'b0;
        checks++;
        assert (lines_valid === 1'b1) else begin
            failures++;
            $error("FAIL %s_timeout observed=no_lines_valid expected=pulse_within_%0d", tag, budget);
        end
        step();
        check({tag, "_idle_ready"}, lock_ready, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_pulse_len"}, lines_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int pulses_before;
        logic [199:0] b;

        rst = 1'b1; frame_tick = 1'b0; lock_valid = 1'b1; lock_board = {200{1'b1}};
        model_total = 16'd0;
        step();
        step();
        check("rst_matrix", objectMatrix, '0);
        check("rst_flash", flash, '0);
        check("rst_ready", lock_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_lines_valid", lines_valid, 1'b0);
        rst = 1'b0;
        lock_valid = 1'b0;
        #1;
        check("post_rst_ready", lock_ready, 1'b1);
        check("post_rst_total", total_lines, 16'd0);
        check("post_rst_cleared", lines_cleared, 5'd0);

        b = '0; b[195] = 1'b1;
        run_event("noclear", b, 1'b0, 20, lat);
        check("noclear_latency", 200'(lat), 200'd1);

        b = '0; b[190 +: 10] = '1; b[185] = 1'b1;
`ifdef TETRIS_LINE_FLASH_EN
        begin
            exp_t e;
            int n;
            e.board = gravity(b, n);
            model_total = model_total + 16'(n);
            e.cleared = 5'(n);
            e.total = model_total;
            check("flash_ready", lock_ready, 1'b1);
            lock_board = b;
            lock_valid = 1'b1;
            sb_q.push_back(e);
            step();
            lock_valid = 1'b0;
            check("flash_scan_off", flash, '0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("flash_first_on", flash, {10'h3FF, 190'd0});
            for (int k = 1; k < 30; k++) begin
                frame_tick = 1'b1;
                step();
                frame_tick = 1'b0;
                check($sformatf("flash_tick%0d", k), flash,
                      ((k / 8) % 2 == 0) ? {10'h3FF, 190'd0} : 200'd0);
                check($sformatf("flash_hold%0d", k), objectMatrix, b);
                step();
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("flash_end_off", flash, '0);
            lat = 0;
            while (lines_valid !== 1'b1 && lat < 60) begin
                step();
                lat++;
            end
            checks++;
            assert (lines_valid === 1'b1) else begin
                failures++;
                $error("FAIL flash_timeout observed=no_lines_valid expected=pulse_within_60");
            end
            step();
        end
`else
        run_event("single", b, 1'b0, 10, lat);
        checks++;
        assert (lat <= 3) else begin
            failures++;
            $error("FAIL single_latency observed=%0d expected=<=3", lat);
        end
`endif

        b = '0; b[160 +: 10] = '1; b[180 +: 10] = '1; b[175] = 1'b1; b[150] = 1'b1;
        run_event("split", b, 1'b0, 200, lat);

        b = '0; b[180 +: 20] = '1; b[0] = 1'b1;
        run_event("adjacent_ignore", b, 1'b1, 200, lat);

        b = {200{1'b1}};
        run_event("all_full", b, 1'b0, 300, lat);

        // Abort mid-event: nothing pushed, so any lines_valid is flagged by the monitor.
        pulses_before = lv_pulses;
        lock_board = {200{1'b1}};
        lock_valid = 1'b1;
        step();
        lock_valid = 1'b0;
        step();
`ifdef TETRIS_LINE_FLASH_EN
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("abort_flash_active", flash, {200{1'b1}});
`else
        step();
`endif
        check("abort_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        check("abort_matrix", objectMatrix, '0);
        check("abort_flash", flash, '0);
        check("abort_busy_clr", busy, 1'b0);
        check("abort_ready_rst", lock_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_ready", lock_ready, 1'b1);
        check("abort_total", total_lines, 16'd0);
        model_total = 16'd0;
        step();
        step();
        step();
        check("abort_no_pulse", 200'(lv_pulses), 200'(pulses_before));

        b = '0; b[0] = 1'b1; b[199] = 1'b1;
        run_event("recover", b, 1'b0, 20, lat);

        check("sb_drained", 200'(sb_q.size()), 200'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
